// File: rtl/branch_resolve_pipe.sv
// Carries fetch prediction metadata to EX, resolves branches/jumps there
// and registers the EX/MEM commit bundle plus perf counters for gshare.
module branch_resolve_pipe #(
  parameter int INDEX_WIDTH   = 8,
  parameter int HISTORY_WIDTH = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          IF_valid_i,
  input  logic [31:0]                   IF_pc_i,
  input  logic                          IF_btb_hit_i,
  input  logic                          IF_prediction_i,
  input  logic [HISTORY_WIDTH-1:0]      IF_ghr_data_i,
  input  logic                          ID_is_branch_i,
  input  logic                          ID_is_jal_i,
  input  logic                          ID_is_jalr_i,
  input  logic [2:0]                    ID_funct3_i,
  input  logic [31:0]                   ID_imm_i,
  input  logic [31:0]                   EX_rs1_data_i,
  input  logic [31:0]                   EX_rs2_data_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  output logic [INDEX_WIDTH-1:0]        EXMEM_btb_wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]     EXMEM_btb_wr_tag_o,
  output logic [31:0]                   EXMEM_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0]      EXMEM_pht_wr_index_o,
  output logic                          EXMEM_btb_hit_o,
  output logic                          EXMEM_prediction_o,
  output logic [HISTORY_WIDTH-1:0]      EXMEM_ghr_data_o,
  output logic                          EXMEM_is_jmp_o,
  output logic                          EXMEM_br_decision_o,
  output logic [31:0]                   EXMEM_pc_plus4_o,
  output logic [31:0]                   EXMEM_br_target_o,
  output logic [CNT_WIDTH-1:0]          br_count_o,
  output logic [CNT_WIDTH-1:0]          mispred_count_o
);

  localparam int HW = HISTORY_WIDTH;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc;
    logic          btb_hit;
    logic          pred;
    logic [HW-1:0] ghr;
  } if_id_t;

  typedef struct packed {
    if_id_t      meta;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic          btb_hit;
    logic          pred;
    logic [HW-1:0] ghr;
    logic          is_jmp;
    logic          taken;
    logic [31:0]   pc_plus4;
    logic [31:0]   target;
  } ex_mem_t;

  if_id_t  if_id_q, if_id_d;
  id_ex_t  id_ex_q, id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;

  logic [CNT_WIDTH-1:0] br_cnt_q, mp_cnt_q;

  always_comb begin
    if_id_d = '0;
    if (IF_valid_i) begin
      if_id_d.valid   = 1'b1;
      if_id_d.pc      = IF_pc_i;
      if_id_d.btb_hit = IF_btb_hit_i;
      if_id_d.pred    = IF_prediction_i;
      if_id_d.ghr     = IF_ghr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if_id_q <= '0;
    end else if (flush_i) begin
      if_id_q <= '0;
    end else if (!stall_i) begin
      if_id_q <= if_id_d;
    end
  end

  always_comb begin
    id_ex_d = '0;
    if (if_id_q.valid) begin
      id_ex_d.meta    = if_id_q;
      id_ex_d.is_br   = ID_is_branch_i;
      id_ex_d.is_jal  = ID_is_jal_i;
      id_ex_d.is_jalr = ID_is_jalr_i;
      id_ex_d.funct3  = ID_funct3_i;
      id_ex_d.imm     = ID_imm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i || stall_i) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  logic        cmp;
  logic        taken;
  logic [31:0] jalr_sum;
  logic [31:0] target;

  always_comb begin
    cmp = 1'b0;
    case (id_ex_q.funct3)
      3'b000:  cmp = EX_rs1_data_i == EX_rs2_data_i;
      3'b001:  cmp = EX_rs1_data_i != EX_rs2_data_i;
      3'b100:  cmp = $signed(EX_rs1_data_i) < $signed(EX_rs2_data_i);
      3'b101:  cmp = $signed(EX_rs1_data_i) >= $signed(EX_rs2_data_i);
      3'b110:  cmp = EX_rs1_data_i < EX_rs2_data_i;
      3'b111:  cmp = EX_rs1_data_i >= EX_rs2_data_i;
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      id_ex_q.is_br:   taken = cmp;
      id_ex_q.is_jal:  taken = 1'b1;
      id_ex_q.is_jalr: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  assign jalr_sum = EX_rs1_data_i + id_ex_q.imm;
  assign target   = id_ex_q.is_jalr ? (jalr_sum & ~32'h1)
                                    : id_ex_q.meta.pc + id_ex_q.imm;

  always_comb begin
    ex_mem_d = '0;
    if (id_ex_q.meta.valid) begin
      ex_mem_d.pc       = id_ex_q.meta.pc;
      ex_mem_d.btb_hit  = id_ex_q.meta.btb_hit;
      ex_mem_d.pred     = id_ex_q.meta.pred;
      ex_mem_d.ghr      = id_ex_q.meta.ghr;
      ex_mem_d.is_jmp   = id_ex_q.is_br | id_ex_q.is_jal;
      ex_mem_d.taken    = taken;
      ex_mem_d.pc_plus4 = id_ex_q.meta.pc + 32'd4;
      ex_mem_d.target   = target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // JALR is not a BTB jump but still redirects, so it counts as a miss
  logic br_inc, mp_inc;

  assign br_inc = ex_mem_q.is_jmp;
  assign mp_inc = (ex_mem_q.is_jmp & (ex_mem_q.pred ^ ex_mem_q.taken))
                | (!ex_mem_q.is_jmp & ex_mem_q.taken);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (br_inc && br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
      if (mp_inc && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign EXMEM_btb_wr_index_o  = ex_mem_q.pc[INDEX_WIDTH+1:2];
  assign EXMEM_btb_wr_tag_o    = ex_mem_q.pc[31:INDEX_WIDTH+2];
  assign EXMEM_btb_wr_target_o = ex_mem_q.target;
  assign EXMEM_pht_wr_index_o  = ex_mem_q.pc[HW+1:2];
  assign EXMEM_btb_hit_o       = ex_mem_q.btb_hit;
  assign EXMEM_prediction_o    = ex_mem_q.pred;
  assign EXMEM_ghr_data_o      = ex_mem_q.ghr;
  assign EXMEM_is_jmp_o        = ex_mem_q.is_jmp;
  assign EXMEM_br_decision_o   = ex_mem_q.taken;
  assign EXMEM_pc_plus4_o      = ex_mem_q.pc_plus4;
  assign EXMEM_br_target_o     = ex_mem_q.target;
  assign br_count_o            = br_cnt_q;
  assign mispred_count_o       = mp_cnt_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({ID_is_branch_i, ID_is_jal_i, ID_is_jalr_i}));

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Bench for branch_resolve_pipe: table-driven stream with a scoreboard
// queue, plus stall, flush, saturation and reset sequences.
module tb_branch_resolve_pipe;

  localparam int IW = 8;
  localparam int HW = 8;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          IF_valid_i;
  logic [31:0]   IF_pc_i;
  logic          IF_btb_hit_i;
  logic          IF_prediction_i;
  logic [HW-1:0] IF_ghr_data_i;
  logic          ID_is_branch_i;
  logic          ID_is_jal_i;
  logic          ID_is_jalr_i;
  logic [2:0]    ID_funct3_i;
  logic [31:0]   ID_imm_i;
  logic [31:0]   EX_rs1_data_i;
  logic [31:0]   EX_rs2_data_i;
  logic          stall_i;
  logic          flush_i;
  logic [IW-1:0]     EXMEM_btb_wr_index_o;
  logic [32-IW-3:0]  EXMEM_btb_wr_tag_o;
  logic [31:0]       EXMEM_btb_wr_target_o;
  logic [HW-1:0]     EXMEM_pht_wr_index_o;
  logic              EXMEM_btb_hit_o;
  logic              EXMEM_prediction_o;
  logic [HW-1:0]     EXMEM_ghr_data_o;
  logic              EXMEM_is_jmp_o;
  logic              EXMEM_br_decision_o;
  logic [31:0]       EXMEM_pc_plus4_o;
  logic [31:0]       EXMEM_br_target_o;
  logic [CW-1:0]     br_count_o;
  logic [CW-1:0]     mispred_count_o;

  branch_resolve_pipe #(
    .INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .IF_valid_i(IF_valid_i), .IF_pc_i(IF_pc_i),
    .IF_btb_hit_i(IF_btb_hit_i), .IF_prediction_i(IF_prediction_i),
    .IF_ghr_data_i(IF_ghr_data_i),
    .ID_is_branch_i(ID_is_branch_i), .ID_is_jal_i(ID_is_jal_i),
    .ID_is_jalr_i(ID_is_jalr_i), .ID_funct3_i(ID_funct3_i),
    .ID_imm_i(ID_imm_i),
    .EX_rs1_data_i(EX_rs1_data_i), .EX_rs2_data_i(EX_rs2_data_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .EXMEM_btb_wr_index_o(EXMEM_btb_wr_index_o),
    .EXMEM_btb_wr_tag_o(EXMEM_btb_wr_tag_o),
    .EXMEM_btb_wr_target_o(EXMEM_btb_wr_target_o),
    .EXMEM_pht_wr_index_o(EXMEM_pht_wr_index_o),
    .EXMEM_btb_hit_o(EXMEM_btb_hit_o),
    .EXMEM_prediction_o(EXMEM_prediction_o),
    .EXMEM_ghr_data_o(EXMEM_ghr_data_o),
    .EXMEM_is_jmp_o(EXMEM_is_jmp_o),
    .EXMEM_br_decision_o(EXMEM_br_decision_o),
    .EXMEM_pc_plus4_o(EXMEM_pc_plus4_o),
    .EXMEM_br_target_o(EXMEM_br_target_o),
    .br_count_o(br_count_o),
    .mispred_count_o(mispred_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          btb;
    bit          pred;
    logic [7:0]  ghr;
    bit          br;
    bit          jal;
    bit          jalr;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          e_jmp;
    bit          e_dec;
    logic [31:0] e_tgt;
    bit          chk_t;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   m_br = 0;
  int   m_mp = 0;

  function automatic vec_t mk(
    bit valid, logic [31:0] pc, bit btb, bit pred, logic [7:0] ghr,
    bit br, bit jal, bit jalr, logic [2:0] f3, logic [31:0] imm,
    logic [31:0] rs1, logic [31:0] rs2,
    bit ej, bit ed, logic [31:0] et, bit ct);
    vec_t v;
    v.valid = valid; v.pc = pc; v.btb = btb; v.pred = pred; v.ghr = ghr;
    v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e_jmp = ej; v.e_dec = ed; v.e_tgt = et; v.chk_t = ct;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    IF_valid_i = 0; IF_pc_i = 0; IF_btb_hit_i = 0;
    IF_prediction_i = 0; IF_ghr_data_i = 0;
    ID_is_branch_i = 0; ID_is_jal_i = 0; ID_is_jalr_i = 0;
    ID_funct3_i = 0; ID_imm_i = 0;
    EX_rs1_data_i = 0; EX_rs2_data_i = 0;
    stall_i = 0; flush_i = 0;
  endtask

  task automatic drive_if(vec_t v);
    IF_valid_i = v.valid; IF_pc_i = v.pc; IF_btb_hit_i = v.btb;
    IF_prediction_i = v.pred; IF_ghr_data_i = v.ghr;
  endtask

  task automatic drive_id(vec_t v);
    ID_is_branch_i = v.br; ID_is_jal_i = v.jal; ID_is_jalr_i = v.jalr;
    ID_funct3_i = v.f3; ID_imm_i = v.imm;
  endtask

  task automatic drive_ex(vec_t v);
    EX_rs1_data_i = v.rs1; EX_rs2_data_i = v.rs2;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_cnt(string nm);
    chk({nm, ".br_count"}, 32'(br_count_o), 32'(m_br));
    chk({nm, ".mispred_count"}, 32'(mispred_count_o), 32'(m_mp));
  endtask

  task automatic chk_zero(string nm);
    chk({nm, ".is_jmp"}, 32'(EXMEM_is_jmp_o), 0);
    chk({nm, ".decision"}, 32'(EXMEM_br_decision_o), 0);
    chk({nm, ".target"}, EXMEM_br_target_o, 0);
    chk({nm, ".pc_plus4"}, EXMEM_pc_plus4_o, 0);
    chk({nm, ".pred"}, 32'(EXMEM_prediction_o), 0);
    chk({nm, ".btb_hit"}, 32'(EXMEM_btb_hit_o), 0);
    chk({nm, ".ghr"}, 32'(EXMEM_ghr_data_o), 0);
    chk({nm, ".index"}, 32'(EXMEM_btb_wr_index_o), 0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 0;
    next_cycle();
    @(negedge clk_i);
    chk_zero("reset");
    chk("reset.br_count", 32'(br_count_o), 0);
    chk("reset.mispred_count", 32'(mispred_count_o), 0);
    m_br = 0;
    m_mp = 0;
    rst_ni = 1;
    next_cycle();
  endtask

  task automatic check_out(vec_t v);
    logic [31:0] epc;
    logic [31:0] ep4;
    bit          epred;
    bit          emp;
    string       nm;
    nm = $sformatf("pc%h", v.pc);
    epc = v.valid ? v.pc : 32'h0;
    ep4 = v.valid ? v.pc + 32'd4 : 32'h0;
    epred = v.valid & v.pred;
    chk({nm, ".is_jmp"}, 32'(EXMEM_is_jmp_o), 32'(v.e_jmp));
    chk({nm, ".decision"}, 32'(EXMEM_br_decision_o), 32'(v.e_dec));
    if (v.chk_t) begin
      chk({nm, ".target"}, EXMEM_br_target_o, v.e_tgt);
      chk({nm, ".btb_target"}, EXMEM_btb_wr_target_o, v.e_tgt);
    end
    chk({nm, ".pc_plus4"}, EXMEM_pc_plus4_o, ep4);
    chk({nm, ".index"}, 32'(EXMEM_btb_wr_index_o), 32'(epc[IW+1:2]));
    chk({nm, ".tag"}, 32'(EXMEM_btb_wr_tag_o), 32'(epc[31:IW+2]));
    chk({nm, ".pht"}, 32'(EXMEM_pht_wr_index_o), 32'(epc[HW+1:2]));
    chk({nm, ".btb_hit"}, 32'(EXMEM_btb_hit_o), 32'(v.valid & v.btb));
    chk({nm, ".pred"}, 32'(EXMEM_prediction_o), 32'(epred));
    chk({nm, ".ghr"}, 32'(EXMEM_ghr_data_o), v.valid ? 32'(v.ghr) : 0);
    emp = (v.e_jmp & (epred ^ v.e_dec)) | (!v.e_jmp & v.e_dec);
    if (v.e_jmp && m_br < 15) m_br++;
    if (emp && m_mp < 15) m_mp++;
  endtask

  task automatic run_stream();
    int n;
    vec_t v;
    n = vecs.size();
    for (int c = 0; c < n + 3; c++) begin
      drive_idle();
      if (c < n) begin
        drive_if(vecs[c]);
        sb.push_back(vecs[c]);
      end
      if (c >= 1 && c - 1 < n) drive_id(vecs[c-1]);
      if (c >= 2 && c - 2 < n) drive_ex(vecs[c-2]);
      @(negedge clk_i);
      chk_cnt("stream");
      if (c >= 3) begin
        v = sb.pop_front();
        check_out(v);
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clk_i);
    chk_cnt("stream_end");
    next_cycle();
  endtask

  vec_t a;

  initial begin
    drive_idle();
    rst_ni = 0;
    repeat (2) next_cycle();
    do_reset();

    vecs = {};
    vecs.push_back(mk(1, 32'h100, 0, 0, 8'h11, 1, 0, 0, 3'b000, 32'h20,
                      32'd5, 32'd5, 1, 1, 32'h120, 1));
    vecs.push_back(mk(1, 32'h200, 0, 0, 8'h22, 0, 0, 1, 3'b000, 32'h4,
                      32'h1003, 0, 0, 1, 32'h1006, 1));
    vecs.push_back(mk(1, 32'h300, 1, 1, 8'h33, 1, 0, 0, 3'b100, 32'h40,
                      32'hFFFFFFFF, 32'd1, 1, 1, 32'h340, 1));
    vecs.push_back(mk(1, 32'h304, 0, 0, 8'h44, 1, 0, 0, 3'b110, 32'h40,
                      32'hFFFFFFFF, 32'd1, 1, 0, 32'h344, 1));
    vecs.push_back(mk(1, 32'h308, 1, 1, 8'h55, 1, 0, 0, 3'b010, 32'h8,
                      0, 0, 1, 0, 32'h310, 1));
    vecs.push_back(mk(1, 32'h400, 1, 1, 8'h66, 1, 0, 0, 3'b001, 32'hFFFFFFF0,
                      32'd1, 32'd2, 1, 1, 32'h3F0, 1));
    vecs.push_back(mk(1, 32'h404, 0, 0, 8'h77, 1, 0, 0, 3'b101, 32'h10,
                      32'h80000000, 0, 1, 0, 32'h414, 1));
    vecs.push_back(mk(1, 32'h408, 0, 0, 8'h88, 1, 0, 0, 3'b111, 32'h10,
                      32'h80000000, 0, 1, 1, 32'h418, 1));
    vecs.push_back(mk(1, 32'h40C, 0, 1, 8'hCC, 1, 0, 0, 3'b101, 32'h4,
                      32'd7, 32'd7, 1, 1, 32'h410, 1));
    vecs.push_back(mk(1, 32'hFFFFFFF0, 1, 1, 8'h99, 0, 1, 0, 3'b000, 32'h20,
                      0, 0, 1, 1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h500, 0, 0, 8'hAA, 0, 0, 0, 3'b000, 32'h100,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h600, 1, 1, 8'hA5, 1, 0, 0, 3'b000, 32'h8,
                      32'd3, 32'd4, 1, 0, 32'h608, 1));
    vecs.push_back(mk(0, 32'h700, 1, 1, 8'hBB, 0, 1, 0, 3'b000, 32'h10,
                      0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h800, 0, 0, 8'h01, 0, 0, 1, 3'b000, 32'hFFFFFFFF,
                      32'h2001, 0, 0, 1, 32'h2000, 1));
    run_stream();

    // stall for two cycles while a branch sits in ID
    do_reset();
    a = mk(1, 32'h880, 1, 1, 8'h3C, 1, 0, 0, 3'b000, 32'h40,
           32'd9, 32'd9, 1, 1, 32'h8C0, 1);
    drive_if(a);
    @(negedge clk_i);
    chk("stall.c0.is_jmp", 32'(EXMEM_is_jmp_o), 0);
    next_cycle();
    for (int c = 1; c <= 6; c++) begin
      drive_idle();
      stall_i = (c == 1 || c == 2);
      if (c <= 3) drive_id(a);
      if (c == 4) drive_ex(a);
      @(negedge clk_i);
      if (c == 5) begin
        chk("stall.is_jmp", 32'(EXMEM_is_jmp_o), 1);
        chk("stall.target", EXMEM_br_target_o, 32'h8C0);
        chk("stall.pc_plus4", EXMEM_pc_plus4_o, 32'h884);
      end else begin
        chk($sformatf("stall.c%0d.is_jmp", c), 32'(EXMEM_is_jmp_o), 0);
      end
      next_cycle();
    end
    @(negedge clk_i);
    chk("stall.br_count", 32'(br_count_o), 1);
    chk("stall.mispred_count", 32'(mispred_count_o), 0);
    next_cycle();

    // flush together with stall empties all three stages
    do_reset();
    a = mk(1, 32'hA00, 0, 0, 8'h5A, 0, 1, 0, 3'b000, 32'h100,
           0, 0, 1, 1, 32'hB00, 1);
    for (int c = 0; c <= 6; c++) begin
      drive_idle();
      if (c <= 3) drive_if(a);
      if (c >= 1) drive_id(a);
      if (c >= 2) drive_ex(a);
      stall_i = (c == 3);
      flush_i = (c == 3);
      @(negedge clk_i);
      if (c == 3) begin
        chk("flush.pre.is_jmp", 32'(EXMEM_is_jmp_o), 1);
        chk("flush.pre.target", EXMEM_br_target_o, 32'hB00);
      end
      if (c >= 4) begin
        chk($sformatf("flush.c%0d.is_jmp", c), 32'(EXMEM_is_jmp_o), 0);
        chk($sformatf("flush.c%0d.decision", c),
            32'(EXMEM_br_decision_o), 0);
      end
      next_cycle();
    end

    // counter saturation with correctly predicted BNEs
    do_reset();
    vecs = {};
    for (int i = 0; i < 20; i++) begin
      logic [31:0] pc;
      pc = 32'h900 + 32'(i * 4);
      vecs.push_back(mk(1, pc, 1, 1, 8'(i), 1, 0, 0, 3'b001, 32'h40,
                        32'd1, 32'd0, 1, 1, pc + 32'h40, 1));
    end
    run_stream();
    chk("sat.br_count", 32'(br_count_o), 15);
    chk("sat.mispred_count", 32'(mispred_count_o), 0);

    // reset in the middle of a stream of JALs
    a = mk(1, 32'hC00, 0, 0, 8'h77, 0, 1, 0, 3'b000, 32'h10,
           0, 0, 1, 1, 32'hC10, 1);
    for (int c = 0; c < 5; c++) begin
      drive_idle();
      drive_if(a);
      drive_id(a);
      next_cycle();
    end
    @(negedge clk_i);
    chk("midrst.pre.is_jmp", 32'(EXMEM_is_jmp_o), 1);
    rst_ni = 0;
    next_cycle();
    @(negedge clk_i);
    chk_zero("midrst");
    chk("midrst.br_count", 32'(br_count_o), 0);
    chk("midrst.mispred_count", 32'(mispred_count_o), 0);
    rst_ni = 1;
    IF_valid_i = 0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk_i);
      chk($sformatf("midrst.c%0d.is_jmp", c), 32'(EXMEM_is_jmp_o), 0);
      chk($sformatf("midrst.c%0d.decision", c), 32'(EXMEM_br_decision_o), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
